// File: rtl/reg_operand_sequencer.sv
// Operand sequencer for a single-read/single-write register file: reads rs1 (and rs2),
// issues operands to the ALU, waits for the result and optionally writes it back to rd.
module reg_operand_sequencer #(
    parameter int DATA_W  = 16,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  req_rs1,
    input  logic [SEL_W-1:0]  req_rs2,
    input  logic [SEL_W-1:0]  req_rd,
    input  logic              req_two_op,
    input  logic              req_wb,
    output logic [SEL_W-1:0]  rf_sel_out,
    output logic              rf_output_enable,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic [SEL_W-1:0]  rf_sel_in,
    output logic              rf_write_enable,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              err_timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_A,
        READ_B,
        ISSUE,
        WAIT_RES,
        WRITE
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic                two_q, two_d, wb_q, wb_d;
    logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        state_d          = state_q;
        rs1_d            = rs1_q;
        rs2_d            = rs2_q;
        rd_d             = rd_q;
        two_d            = two_q;
        wb_d             = wb_q;
        opa_d            = opa_q;
        opb_d            = opb_q;
        res_d            = res_q;
        cnt_d            = cnt_q;
        req_ready        = 1'b0;
        rf_sel_out       = '0;
        rf_output_enable = 1'b0;
        rf_sel_in        = '0;
        rf_write_enable  = 1'b0;
        rf_data_in       = '0;
        op_valid         = 1'b0;
        res_ready        = 1'b0;
        err_timeout      = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    rd_d    = req_rd;
                    two_d   = req_two_op;
                    wb_d    = req_wb;
                    state_d = READ_A;
                end
            end
            READ_A: begin
                rf_sel_out       = rs1_q;
                rf_output_enable = 1'b1;
                opa_d            = rf_data_out;
                if (two_q) begin
                    state_d = READ_B;
                end else begin
                    opb_d   = '0;
                    state_d = ISSUE;
                end
            end
            READ_B: begin
                rf_sel_out       = rs2_q;
                rf_output_enable = 1'b1;
                opb_d            = rf_data_out;
                state_d          = ISSUE;
            end
            ISSUE: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    res_d   = res_data;
                    state_d = wb_q ? WRITE : IDLE;
                end else if (TIMEOUT > 0) begin
                    // cnt_q counts completed result-less cycles; the last one aborts
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_timeout = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                rf_sel_in       = rd_q;
                rf_data_in      = res_q;
                rf_write_enable = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobes are squelched while reset is held so no write or handshake slips out.
        if (rst) begin
            req_ready        = 1'b0;
            rf_output_enable = 1'b0;
            rf_write_enable  = 1'b0;
            op_valid         = 1'b0;
            res_ready        = 1'b0;
            err_timeout      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            two_q   <= 1'b0;
            wb_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            two_q   <= two_d;
            wb_q    <= wb_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign op_a = opa_q;
    assign op_b = opb_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_reg_operand_sequencer.sv
// Directed plus randomized bench: a TB-owned register file and ALU responder, with an
// array-based reference of register contents and expected operands/results.
module tb_reg_operand_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_rs1, req_rs2, req_rd;
    logic        req_two_op, req_wb;
    logic [2:0]  rf_sel_out, rf_sel_in;
    logic        rf_output_enable, rf_write_enable;
    wire  [15:0] rf_data_out;
    logic [15:0] rf_data_in;
    logic        op_valid, op_ready;
    logic [15:0] op_a, op_b;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic        busy, err_timeout;

    int nvec = 0;
    int nerr = 0;
    int n_wr = 0;
    int exp_wr = 0;

    logic [15:0] rf_mem  [8];
    logic [15:0] ref_mem [8];
    logic        pre_we;
    logic [2:0]  pre_sel;
    logic [15:0] pre_data;

    reg_operand_sequencer #(.DATA_W(16), .SEL_W(3), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .req_two_op(req_two_op), .req_wb(req_wb),
        .rf_sel_out(rf_sel_out), .rf_output_enable(rf_output_enable), .rf_data_out(rf_data_out),
        .rf_sel_in(rf_sel_in), .rf_write_enable(rf_write_enable), .rf_data_in(rf_data_in),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_write_enable) rf_mem[rf_sel_in] <= rf_data_in;
        else if (pre_we)     rf_mem[pre_sel]   <= pre_data;
        if (rf_write_enable) n_wr <= n_wr + 1;
    end
    assign rf_data_out = rf_output_enable ? rf_mem[rf_sel_out] : 16'hzzzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int r, input logic [15:0] v);
        pre_we = 1'b1; pre_sel = 3'(r); pre_data = v;
        @(negedge clk);
        pre_we = 1'b0;
        ref_mem[r] = v;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic check_mem(input string tag);
        for (int r = 0; r < 8; r++) chk(tag, rf_mem[r], ref_mem[r]);
    endtask

    // One full instruction; all expectations come from ref_mem and the rules for the op.
    task automatic txn(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                       input logic two, input logic wb, input int rdy, input logic early,
                       input logic respond, input int rdly);
        logic [15:0] ea, eb, er;
        int cyc, en;
        ea = ref_mem[rs1];
        eb = two ? ref_mem[rs2] : 16'h0;
        er = ea + eb;
        wait_ready();
        req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
        req_two_op = two; req_wb = wb;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        cyc = 1; en = 0;
        while (op_valid !== 1'b1 && cyc < 10) begin
            if (rf_output_enable === 1'b1) en++;
            if (cyc == 1) chk("sel_out_rs1", rf_sel_out, rs1);
            if (cyc == 2) chk("sel_out_rs2", rf_sel_out, rs2);
            @(negedge clk);
            cyc++;
        end
        chk("op_valid_cycle", cyc, two ? 3 : 2);
        chk("enable_cycles", en, two ? 2 : 1);
        chk("op_a", op_a, ea);
        chk("op_b", op_b, eb);
        chk("oe_in_issue", {31'd0, rf_output_enable}, 32'd0);
        op_ready = 1'b0;
        for (int i = 0; i < rdy; i++) begin
            res_valid = early; res_data = 16'hDEAD;
            @(negedge clk);
            chk("op_valid_hold", {31'd0, op_valid}, 32'd1);
            chk("op_a_stable", op_a, ea);
            chk("op_b_stable", op_b, eb);
            chk("res_ready_in_issue", {31'd0, res_ready}, 32'd0);
        end
        res_valid = 1'b0; res_data = 16'h0;
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        chk("res_ready_wait", {31'd0, res_ready}, 32'd1);
        chk("op_valid_after_hs", {31'd0, op_valid}, 32'd0);
        if (respond) begin
            for (int i = 0; i < rdly; i++) begin
                @(negedge clk);
                chk("res_ready_wait", {31'd0, res_ready}, 32'd1);
            end
            res_valid = 1'b1; res_data = er;
            @(negedge clk);
            res_valid = 1'b0; res_data = 16'h0;
            if (wb) begin
                chk("write_strobe", {31'd0, rf_write_enable}, 32'd1);
                chk("sel_in", rf_sel_in, rd);
                chk("data_in", rf_data_in, er);
                ref_mem[rd] = er;
                exp_wr++;
                @(negedge clk);
            end
        end else begin
            for (int k = 1; k <= 8; k++) begin
                chk("err_timeout", {31'd0, err_timeout}, (k == 8) ? 32'd1 : 32'd0);
                @(negedge clk);
            end
            chk("err_timeout_pulse_end", {31'd0, err_timeout}, 32'd0);
        end
        chk("we_idle", {31'd0, rf_write_enable}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        chk("write_count", n_wr, exp_wr);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
        req_two_op = 1'b0; req_wb = 1'b0; op_ready = 1'b0; res_valid = 1'b0;
        res_data = '0; pre_we = 1'b0; pre_sel = '0; pre_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_op_b", op_b, 32'd0);
        chk("rst_we", {31'd0, rf_write_enable}, 32'd0);
        chk("rst_oe", {31'd0, rf_output_enable}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rst", {31'd0, req_ready}, 32'd1);

        for (int r = 0; r < 8; r++) load(r, 16'(r * 16'h0101));
        load(2, 16'h1234);
        load(5, 16'h00FF);
        load(7, 16'hBEEF);

        txn(3'd2, 3'd5, 3'd3, 1'b1, 1'b1, 0, 1'b0, 1'b1, 0);
        chk("R3_sum", rf_mem[3], 32'h1333);
        txn(3'd7, 3'd0, 3'd1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1);
        txn(3'd2, 3'd2, 3'd2, 1'b1, 1'b1, 5, 1'b1, 1'b1, 2);
        txn(3'd5, 3'd1, 3'd6, 1'b1, 1'b1, 1, 1'b0, 1'b0, 0);

        wait_ready();
        req_valid = 1'b1; req_rs1 = 3'd2; req_rs2 = 3'd5; req_rd = 3'd0;
        req_two_op = 1'b1; req_wb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("readb_sel", rf_sel_out, 32'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_op_a", op_a, 32'd0);
        chk("rstmid_op_b", op_b, 32'd0);
        chk("rstmid_oe", {31'd0, rf_output_enable}, 32'd0);
        chk("rstmid_sel_out", rf_sel_out, 32'd0);
        chk("rstmid_op_valid", {31'd0, op_valid}, 32'd0);
        chk("rstmid_req_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_req_ready_after", {31'd0, req_ready}, 32'd1);
        chk("rstmid_write_count", n_wr, exp_wr);
        check_mem("mem_after_rst");

        load(6, 16'h0040);
        load(1, 16'h0002);
        txn(3'd6, 3'd1, 3'd4, 1'b1, 1'b1, 0, 1'b0, 1'b1, 0);
        txn(3'd4, 3'd0, 3'd5, 1'b0, 1'b0, 0, 1'b0, 1'b1, 0);
        chk("R4_value", rf_mem[4], 32'h0042);

        for (int t = 0; t < 20; t++) begin
            if (t % 5 == 0) load($urandom_range(0, 7), 16'($urandom));
            txn(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), (t % 7 != 6), $urandom_range(0, 3));
        end
        check_mem("mem_final");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
